stack_unit: RTL and testbench

- Operand stack that the multicycle stack-CPU controller drives through its tos, pop and push strobes.
- It answers each strobe with a registered top/popped value on dout. The datapath latches dout into A/B or uses it as a memory address.
- Push data comes from the datapath mux (memory data or ALU result), which the controller selects with MtoS. That mux is outside this block.
- The block keeps the stack pointer, storage, occupancy count and sticky error flags.

---
 rtl/stack_unit.sv | 84 ++++++++
 tb/tb_stack_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack-CPU controller.
// Strobe semantics: push, pop and tos are single-cycle command strobes that
// the controller asserts for one cycle at a time. There is no ready/backpressure.
// If exactly one strobe is high, the command is sampled on the rising edge.
// If more than one is high, the encoding is illegal: it is rejected and flagged.
// dout holds the result of the last successful pop/tos. It is valid in the cycle
// after the strobe edge and stays stable until the next successful pop/tos.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              unf,
  output logic              cmd_err
);

  localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    sp;
  logic              multi;
  logic              do_push;
  logic              do_pop;
  logic              do_tos;
  logic              ovf_hit;
  logic              unf_hit;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  rd_idx;
  logic [DATA_W-1:0] top_data;

  // sp is the next free slot, so it equals the occupancy directly
  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == DEPTH_C);

  // Decode the strobes and form the storage indices, held at 0 when out of range
  always_comb begin
    multi    = (push & pop) | (push & tos) | (pop & tos);
    do_push  = push & ~multi & ~full;
    ovf_hit  = push & ~multi & full;
    do_pop   = pop & ~multi & ~empty;
    do_tos   = tos & ~multi & ~empty;
    unf_hit  = (pop | tos) & ~multi & empty;
    wr_idx   = full  ? '0 : sp[PTR_W-1:0];
    rd_idx   = empty ? '0 : (sp[PTR_W-1:0] - PTR_W'(1));
    top_data = mem[rd_idx];
  end

  // Pointer, output register and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp      <= '0;
      dout    <= '0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      if (do_push) sp <= sp + ONE;
      if (do_pop)  sp <= sp - ONE;
      if (do_pop || do_tos) dout <= top_data;
      if (ovf_hit) ovf     <= 1'b1;
      if (unf_hit) unf     <= 1'b1;
      if (multi)   cmd_err <= 1'b1;
    end
  end

  // Storage array; contents are don't-care after reset, so it is not cleared
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: directed scenarios followed by random
// strobe traffic, all checked against a queue-based LIFO reference model.
module tb_stack_unit;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic          tos = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic [PW:0]   count;
  logic          empty, full, ovf, unf, cmd_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: the stack as a queue, plus expected output registers
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf, m_unf, m_cmd_err;

  stack_unit #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .tos(tos), .din(din),
    .dout(dout), .count(count), .empty(empty), .full(full),
    .ovf(ovf), .unf(unf), .cmd_err(cmd_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_dout    = '0;
    m_ovf     = 1'b0;
    m_unf     = 1'b0;
    m_cmd_err = 1'b0;
  endtask

  task automatic model_update(input logic p, input logic o, input logic t, input logic [DW-1:0] d);
    int n;
    n = int'(p) + int'(o) + int'(t);
    if (n > 1) m_cmd_err = 1'b1;
    else if (p) begin
      if (exp_q.size() == DEPTH) m_ovf = 1'b1;
      else exp_q.push_back(d);
    end else if (o) begin
      if (exp_q.size() == 0) m_unf = 1'b1;
      else m_dout = exp_q.pop_back();
    end else if (t) begin
      if (exp_q.size() == 0) m_unf = 1'b1;
      else m_dout = exp_q[$];
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_dout"},  32'(dout),    32'(m_dout));
    check({tag, "_count"}, 32'(count),   32'(exp_q.size()));
    check({tag, "_empty"}, 32'(empty),   32'(exp_q.size() == 0));
    check({tag, "_full"},  32'(full),    32'(exp_q.size() == DEPTH));
    check({tag, "_ovf"},   32'(ovf),     32'(m_ovf));
    check({tag, "_unf"},   32'(unf),     32'(m_unf));
    check({tag, "_cerr"},  32'(cmd_err), 32'(m_cmd_err));
  endtask

  // Driver: apply one cycle of strobes, update the model, check after the edge
  task automatic step(input string tag, input logic p, input logic o, input logic t,
                      input logic [DW-1:0] d);
    push = p; pop = o; tos = t; din = d;
    @(posedge clk);
    model_update(p, o, t, d);
    #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0;
    check_all(tag);
  endtask

  task automatic sync_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all("reset");
    check("reset_empty_const", 32'(empty), 32'd1);

    // Basic push / tos / pop ordering
    step("t1_push", 1, 0, 0, 8'h11);
    step("t1_push", 1, 0, 0, 8'h22);
    step("t1_push", 1, 0, 0, 8'h33);
    check("t1_count3", 32'(count), 32'd3);
    step("t1_tos", 0, 0, 1, 8'h00);
    check("t1_tos_dout", 32'(dout), 32'h33);
    step("t1_pop", 0, 1, 0, 8'h00);
    check("t1_pop1", 32'(dout), 32'h33);
    step("t1_pop", 0, 1, 0, 8'h00);
    check("t1_pop2", 32'(dout), 32'h22);
    step("t1_pop", 0, 1, 0, 8'h00);
    check("t1_pop3", 32'(dout), 32'h11);
    check("t1_empty", 32'(empty), 32'd1);

    // Fill to capacity, overflow, then pop the real top
    for (int i = 0; i < DEPTH; i++) step("t3_fill", 1, 0, 0, DW'(i));
    check("t3_full", 32'(full), 32'd1);
    step("t3_ovf_push", 1, 0, 0, 8'hAA);
    check("t3_ovf", 32'(ovf), 32'd1);
    check("t3_count", 32'(count), 32'd16);
    step("t3_pop", 0, 1, 0, 8'h00);
    check("t3_pop_dout", 32'(dout), 32'h0F);

    // Controller-style ALU sequence from a clean reset
    sync_reset();
    step("t2", 1, 0, 0, 8'h05);
    step("t2", 1, 0, 0, 8'h07);
    step("t2_popa", 0, 1, 0, 8'h00);
    check("t2_a", 32'(dout), 32'h07);
    step("t2_idle", 0, 0, 0, 8'h00);
    step("t2_popb", 0, 1, 0, 8'h00);
    check("t2_b", 32'(dout), 32'h05);
    step("t2_res", 1, 0, 0, 8'h0C);
    check("t2_count", 32'(count), 32'd1);
    step("t2_tos", 0, 0, 1, 8'h00);
    check("t2_tos_dout", 32'(dout), 32'h0C);
    check("t2_noerr", 32'({ovf, unf, cmd_err}), 32'd0);

    // Underflow: drain, then pop/tos while empty
    step("t4_drain", 0, 1, 0, 8'h00);
    step("t4_unf_pop", 0, 1, 0, 8'h00);
    check("t4_unf", 32'(unf), 32'd1);
    check("t4_dout_hold", 32'(dout), 32'h0C);
    step("t4_unf_tos", 0, 0, 1, 8'h00);
    step("t4_push", 1, 0, 0, 8'h44);
    step("t4_pop", 0, 1, 0, 8'h00);
    check("t4_dout", 32'(dout), 32'h44);
    check("t4_unf_sticky", 32'(unf), 32'd1);

    // Illegal simultaneous strobes
    step("t5", 1, 0, 0, 8'h01);
    step("t5", 1, 0, 0, 8'h02);
    step("t5_multi", 1, 1, 0, 8'h99);
    check("t5_cerr", 32'(cmd_err), 32'd1);
    check("t5_count", 32'(count), 32'd2);
    step("t5_tos", 0, 0, 1, 8'h00);
    check("t5_tos_dout", 32'(dout), 32'h02);

    // Asynchronous reset between edges while pop is held
    sync_reset();
    step("t6", 1, 0, 0, 8'hA1);
    step("t6", 1, 0, 0, 8'hA2);
    step("t6", 1, 0, 0, 8'hA3);
    pop = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("t6_async");
    check("t6_async_count", 32'(count), 32'd0);
    pop = 1'b0;
    rst = 1'b0;
    step("t6_tos", 0, 0, 1, 8'h00);
    check("t6_unf", 32'(unf), 32'd1);

    // Random traffic, re-armed by reset every block so flags stay informative
    for (int blk = 0; blk < 4; blk++) begin
      sync_reset();
      check_all("rnd_reset");
      for (int c = 0; c < 150; c++) begin
        int r;
        logic [DW-1:0] d;
        r = $urandom_range(0, 99);
        d = DW'($urandom_range(0, 255));
        if (r < 45)      step("rnd", 1, 0, 0, d);
        else if (r < 75) step("rnd", 0, 1, 0, d);
        else if (r < 88) step("rnd", 0, 0, 1, d);
        else if (r < 96) step("rnd", 0, 0, 0, d);
        else begin
          logic [2:0] s;
          s = 3'($urandom_range(3, 7));
          if (s == 3'd4) s = 3'd7;
          step("rnd_multi", s[2], s[1], s[0], d);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
